// File: rtl/apb_banked_sram_slave.sv
// APB4 slave fronting NUM_BANKS word-wide SRAM banks with programmable wait
// states, per-bank write protection, PSLVERR on bad accesses and a saturating
// error counter.
module apb_banked_sram_slave #(
  parameter int unsigned          DATA_WIDTH  = 32,
  parameter int unsigned          ADDR_WIDTH  = 12,
  parameter int unsigned          NUM_BANKS   = 4,
  parameter int unsigned          BANK_DEPTH  = 64,
  parameter int unsigned          WAIT_CYCLES = 1,
  parameter logic [NUM_BANKS-1:0] RO_MASK     = '0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR,
  output logic [7:0]              err_count
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned BL     = $clog2(NBYTES);
  localparam int unsigned WORD_W = ADDR_WIDTH - BL;
  localparam int unsigned TOTAL  = NUM_BANKS * BANK_DEPTH;
  localparam int unsigned IDX_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int unsigned OFF_W  = $clog2(BANK_DEPTH);
  localparam int unsigned BNK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    wr_q, wr_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    pready_q, pready_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    pslverr_q, pslverr_d;
  logic [7:0]              errcnt_q, errcnt_d;

  logic [DATA_WIDTH-1:0]   mem [TOTAL];
  logic                    mem_we_c;

  logic [WORD_W-1:0]       word_c;
  logic [BNK_W-1:0]        bank_c;
  logic [IDX_W-1:0]        idx_c;
  logic                    misalign_c, range_c, ro_c, err_c;

  // Address decode and error classification of the current setup request
  always_comb begin
    word_c     = WORD_W'(PADDR >> BL);
    idx_c      = IDX_W'(word_c);
    bank_c     = BNK_W'(word_c >> OFF_W);
    misalign_c = (PADDR & ADDR_WIDTH'(NBYTES - 1)) != '0;
    range_c    = 32'(word_c) >= TOTAL;
    ro_c       = PWRITE && !range_c && RO_MASK[bank_c];
    err_c      = misalign_c || range_c || ro_c;
  end

  // Next-state and registered-output logic; PREADY is registered so it is
  // pre-computed as "wait counter reaches zero next cycle"
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    prdata_d  = prdata_q;
    errcnt_d  = errcnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    mem_we_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          idx_d   = idx_c;
          wr_d    = PWRITE;
          err_d   = err_c;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          if (!PWRITE && !err_c) rdata_d = mem[idx_c];
          if (WAIT_CYCLES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = err_c;
            if (err_c)        prdata_d = '0;
            else if (!PWRITE) prdata_d = mem[idx_c];
          end
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          // Protocol abort: drop the transfer silently
          state_d = IDLE;
        end else if (PENABLE && pready_q) begin
          state_d  = IDLE;
          mem_we_c = wr_q && !err_q;
          if (err_q && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'd1;
        end else begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          pready_d  = (cnt_d == '0);
          pslverr_d = pready_d && err_q;
          if (pready_d && !pready_q) begin
            if (err_q)      prdata_d = '0;
            else if (!wr_q) prdata_d = rdata_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      errcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      errcnt_q  <= errcnt_d;
    end
  end

  // Byte-lane write into the SRAM array at the completion edge (not reset)
  always_ff @(posedge PCLK) begin
    if (mem_we_c) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (PSTRB[b]) mem[idx_q][b*8 +: 8] <= PWDATA[b*8 +: 8];
      end
    end
  end

  assign PREADY    = pready_q;
  assign PRDATA    = prdata_q;
  assign PSLVERR   = pslverr_q;
  assign err_count = errcnt_q;

endmodule
